// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues imem reads, buffers one word while
// IF/ID is stalled, and squashes in-flight fetches when EX redirects.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_read_o,
  output logic [31:0] imem_address_o,
  input  logic        imem_resp_i,
  input  logic [31:0] imem_rdata_i,
  output logic        ifid_en_o,
  output logic        ifid_flush_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] instr_o,
  output logic [1:0]  fsm_state
);

  // Handshake: imem_read_o/imem_address_o hold steady until imem_resp_i is seen;
  // a response is consumed in the cycle it is asserted, there is no backpressure.
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    HOLD = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic [31:0] buf_q, buf_d;
  logic        valid;
  logic [31:0] word;

  assign fsm_state = state_q;
  assign valid     = ((state_q == REQ) && imem_resp_i) || (state_q == HOLD);
  assign word      = (state_q == HOLD) ? buf_q : imem_rdata_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
      buf_q       <= NOP_INSN;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      buf_q       <= buf_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    drop_addr_d    = drop_addr_q;
    buf_d          = buf_q;
    ifid_en_o      = 1'b0;
    ifid_flush_o   = 1'b0;
    pc_o           = pc_q;
    instr_o        = NOP_INSN;
    imem_read_o    = (state_q != HOLD);
    imem_address_o = (state_q == DROP) ? drop_addr_q : pc_q;

    if (!rst) begin
      imem_read_o = 1'b0;
      pc_o        = RESET_PC;
    end else if (redirect_i) begin
      ifid_en_o    = 1'b1;
      ifid_flush_o = 1'b1;
      pc_d         = redirect_pc_i;
      case (state_q)
        REQ: begin
          if (!imem_resp_i) begin
            drop_addr_d = pc_q;
            state_d     = DROP;
          end
        end
        HOLD:    state_d = REQ;
        // The stale request already in flight still has to complete before refetching.
        DROP:    state_d = imem_resp_i ? REQ : DROP;
        default: state_d = REQ;
      endcase
    end else if (valid && !stall_i) begin
      ifid_en_o = 1'b1;
      instr_o   = word;
      pc_d      = pc_q + 32'd4;
      state_d   = REQ;
    end else begin
      if ((state_q == REQ) && imem_resp_i) begin
        buf_d   = imem_rdata_i;
        state_d = HOLD;
      end else if ((state_q == DROP) && imem_resp_i) begin
        state_d = REQ;
      end
      if (!stall_i) begin
        ifid_en_o    = 1'b1;
        ifid_flush_o = 1'b1;
      end
    end
  end

  assign pc_plus4_o = pc_o + 32'd4;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: inputs are driven after the falling edge and the
// combinational outputs are compared with hand-computed values before the next rising edge.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_read_o;
  logic [31:0] imem_address_o;
  logic        imem_resp_i;
  logic [31:0] imem_rdata_i;
  logic        ifid_en_o;
  logic        ifid_flush_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [31:0] instr_o;
  logic [1:0]  fsm_state;

  int checks;
  int errors;
  logic [31:0] exp_q[$];

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_read_o(imem_read_o),
    .imem_address_o(imem_address_o), .imem_resp_i(imem_resp_i),
    .imem_rdata_i(imem_rdata_i), .ifid_en_o(ifid_en_o), .ifid_flush_o(ifid_flush_o),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .instr_o(instr_o), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver: apply one cycle of inputs after the falling edge
  task automatic drive(input logic r, input logic st, input logic rd, input logic [31:0] rpc,
                       input logic resp, input logic [31:0] rdata);
    @(negedge clk);
    rst           = r;
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    imem_resp_i   = resp;
    imem_rdata_i  = rdata;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic rd, input logic [31:0] addr,
                            input logic en, input logic fl, input logic [31:0] pc,
                            input logic [31:0] ins);
    check({tag, "_read"}, {31'd0, imem_read_o}, {31'd0, rd});
    if (rd) check({tag, "_addr"}, imem_address_o, addr);
    check({tag, "_en"}, {31'd0, ifid_en_o}, {31'd0, en});
    check({tag, "_flush"}, {31'd0, ifid_flush_o}, {31'd0, fl});
    check({tag, "_pc"}, pc_o, pc);
    check({tag, "_pc4"}, pc_plus4_o, pc + 32'd4);
    check({tag, "_instr"}, instr_o, ins);
  endtask

  // scoreboard: the next delivered word must be the head of exp_q
  task automatic expect_deliver(input string tag, input logic rd, input logic [31:0] addr,
                                input logic [31:0] pc);
    logic [31:0] w;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      w = exp_q.pop_front();
      expect_out(tag, rd, addr, 1'b1, 1'b0, pc, w);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_resp_i = 1'b0; imem_rdata_i = '0;
    exp_q.push_back(32'h1111_0000);
    exp_q.push_back(32'h1111_0004);
    exp_q.push_back(32'h1111_0008);
    exp_q.push_back(32'h2222_006C);
    exp_q.push_back(32'h3333_0200);
    exp_q.push_back(32'h5555_0400);
    exp_q.push_back(32'h7777_FFFC);
    exp_q.push_back(32'h8888_0060);

    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    expect_out("rst", 1'b0, '0, 1'b0, 1'b0, 32'h60, NOP);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);

    // 1: back-to-back fetch with single-cycle memory
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 32'h1111_0000);
    expect_deliver("f60", 1'b1, 32'h60, 32'h60);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 32'h1111_0004);
    expect_deliver("f64", 1'b1, 32'h64, 32'h64);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 32'h1111_0008);
    expect_deliver("f68", 1'b1, 32'h68, 32'h68);

    // 2: response under stall is buffered and delivered once the stall lifts
    drive(1'b1, 1'b1, 1'b0, '0, 1'b1, 32'h2222_006C);
    expect_out("stl_resp", 1'b1, 32'h6C, 1'b0, 1'b0, 32'h6C, NOP);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0, '0, 1'b0, 32'hDEAD_0000);
      expect_out("stl_hold", 1'b0, '0, 1'b0, 1'b0, 32'h6C, NOP);
      check("stl_state", {30'd0, fsm_state}, 32'd1);
    end
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 32'hDEAD_0001);
    expect_deliver("hold_dlv", 1'b0, '0, 32'h6C);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    expect_out("bub70", 1'b1, 32'h70, 1'b1, 1'b1, 32'h70, NOP);

    // 3: redirect while a slow request is pending
    drive(1'b1, 1'b0, 1'b1, 32'h200, 1'b0, '0);
    expect_out("rdr_flush", 1'b1, 32'h70, 1'b1, 1'b1, 32'h70, NOP);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    expect_out("drop_wait", 1'b1, 32'h70, 1'b1, 1'b1, 32'h200, NOP);
    check("drop_state", {30'd0, fsm_state}, 32'd2);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 32'hBAD0_0070);
    expect_out("drop_resp", 1'b1, 32'h70, 1'b1, 1'b1, 32'h200, NOP);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 32'h3333_0200);
    expect_deliver("f200", 1'b1, 32'h200, 32'h200);

    // 4: redirect in the same cycle as a response
    drive(1'b1, 1'b0, 1'b1, 32'h300, 1'b1, 32'hBAD0_0204);
    expect_out("rdr_resp", 1'b1, 32'h204, 1'b1, 1'b1, 32'h204, NOP);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    expect_out("bub300", 1'b1, 32'h300, 1'b1, 1'b1, 32'h300, NOP);

    // 5: redirect while stalled in HOLD drops the buffered word
    drive(1'b1, 1'b1, 1'b0, '0, 1'b1, 32'hBAD0_0300);
    expect_out("stl300", 1'b1, 32'h300, 1'b0, 1'b0, 32'h300, NOP);
    drive(1'b1, 1'b1, 1'b1, 32'h400, 1'b0, '0);
    expect_out("rdr_hold", 1'b0, '0, 1'b1, 1'b1, 32'h300, NOP);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 32'h5555_0400);
    expect_deliver("f400", 1'b1, 32'h400, 32'h400);

    // 6: PC wrap, then reset in the middle of a request
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hBAD0_0404);
    expect_out("rdr_top", 1'b1, 32'h404, 1'b1, 1'b1, 32'h404, NOP);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 32'h7777_FFFC);
    expect_deliver("ftop", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    expect_out("wrap0", 1'b1, 32'h0, 1'b1, 1'b1, 32'h0, NOP);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'hBAD0_0000);
    expect_out("mid_rst", 1'b0, '0, 1'b0, 1'b0, 32'h60, NOP);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    expect_out("post_rst", 1'b1, 32'h60, 1'b1, 1'b1, 32'h60, NOP);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 32'h8888_0060);
    expect_deliver("f60b", 1'b1, 32'h60, 32'h60);

    check("sb_empty", exp_q.size(), 32'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
